// File: rtl/rca32_if.sv
// rtl/rca32_if.sv - operand/result bundle for the registered ripple-carry adder
interface rca32_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Cin;
    logic [WIDTH-1:0] sum;
    logic             Cout;
    logic             of;

    modport master (
        output a,
        output b,
        output Cin,
        input  sum,
        input  Cout,
        input  of
    );

    modport slave (
        input  a,
        input  b,
        input  Cin,
        output sum,
        output Cout,
        output of
    );
endinterface

// File: rtl/rca32.sv
// rtl/rca32.sv - WIDTH-bit ripple-carry adder with registered sum, carry-out and signed overflow
module rca32 #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    rca32_if.slave      bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             of_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             of_q;

    // One full-adder cell per bit; carry[i] feeds cell i, carry[i+1] is its carry-out.
    always_comb begin
        carry    = '0;
        sum_d    = '0;
        carry[0] = bus.Cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i]     = bus.a[i] ^ bus.b[i] ^ carry[i];
            carry[i + 1] = (bus.a[i] & bus.b[i])
                         | (bus.a[i] & carry[i])
                         | (bus.b[i] & carry[i]);
        end
        cout_d = carry[WIDTH];
        of_d   = carry[WIDTH] ^ carry[WIDTH - 1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            of_q   <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            of_q   <= of_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.of   = of_q;
endmodule

// File: tb/tb_rca32.sv
// tb/tb_rca32.sv - directed and random checks of the registered ripple-carry adder
module tb_rca32;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rca32_if #(.WIDTH(32)) bus ();

    rca32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        @(negedge clk);
        bus.a   = av;
        bus.b   = bv;
        bus.Cin = cv;
    endtask

    task automatic test_reset;
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'h0 || bus.Cout !== 1'b0 || bus.of !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got sum=%h Cout=%b of=%b want sum=00000000 Cout=0 of=0",
                     bus.sum, bus.Cout, bus.of);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'hFFFFFFFE || bus.Cout !== 1'b1 || bus.of !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got sum=%h Cout=%b of=%b want sum=fffffffe Cout=1 of=0",
                     bus.sum, bus.Cout, bus.of);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta [7] = '{32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'h12345678,
                                32'hFFFFFFFF, 32'hFFFFF999, 32'h00000420};
        logic [31:0] tb [7] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345670,
                                32'hFFFFFFFF, 32'h00000111, 32'h00000420};
        logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] es [7] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'h92345678, 32'h2468ACE9,
                                32'hFFFFFFFE, 32'hFFFFFAAA, 32'h00000841};
        logic        ec [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        eo [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(ta[i], tb[i], tc[i]);
            @(posedge clk); #1;
            checks++;
            if (bus.sum !== es[i] || bus.Cout !== ec[i] || bus.of !== eo[i]) begin
                errors++;
                $display("FAIL directed_%0d: got sum=%h Cout=%b of=%b want sum=%h Cout=%b of=%b",
                         i, bus.sum, bus.Cout, bus.of, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_boundary;
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'hFFFFFFFF || bus.Cout !== 1'b1 || bus.of !== 1'b0) begin
            errors++;
            $display("FAIL ones_plus_ones_cin: got sum=%h Cout=%b of=%b want sum=ffffffff Cout=1 of=0",
                     bus.sum, bus.Cout, bus.of);
        end
        drive(32'h0, 32'h0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'h1 || bus.Cout !== 1'b0 || bus.of !== 1'b0) begin
            errors++;
            $display("FAIL zero_cin: got sum=%h Cout=%b of=%b want sum=00000001 Cout=0 of=0",
                     bus.sum, bus.Cout, bus.of);
        end
        drive(32'h80000000, 32'h80000000, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'h0 || bus.Cout !== 1'b1 || bus.of !== 1'b1) begin
            errors++;
            $display("FAIL both_flags: got sum=%h Cout=%b of=%b want sum=00000000 Cout=1 of=1",
                     bus.sum, bus.Cout, bus.of);
        end
        drive(32'hFFFFFFFF, 32'h0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'h0 || bus.Cout !== 1'b1 || bus.of !== 1'b0) begin
            errors++;
            $display("FAIL full_ripple: got sum=%h Cout=%b of=%b want sum=00000000 Cout=1 of=0",
                     bus.sum, bus.Cout, bus.of);
        end
    endtask

    task automatic test_latency;
        drive(32'h00000010, 32'h00000020, 1'b0);
        @(posedge clk); #1;
        bus.a   = 32'h00001000;
        bus.b   = 32'h00002000;
        bus.Cin = 1'b1;
        #6;
        checks++;
        if (bus.sum !== 32'h00000030 || bus.Cout !== 1'b0 || bus.of !== 1'b0) begin
            errors++;
            $display("FAIL latency_hold: got sum=%h Cout=%b of=%b want sum=00000030 Cout=0 of=0",
                     bus.sum, bus.Cout, bus.of);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'h00003001) begin
            errors++;
            $display("FAIL latency_update: got sum=%h want sum=00003001", bus.sum);
        end
    endtask

    task automatic test_reset_midstream;
        drive(32'h11111111, 32'h22222222, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'h0 || bus.Cout !== 1'b0 || bus.of !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got sum=%h Cout=%b of=%b want all zero",
                     bus.sum, bus.Cout, bus.of);
        end
        drive(32'h00000005, 32'h00000006, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'h0000000B || bus.Cout !== 1'b0 || bus.of !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: got sum=%h Cout=%b of=%b want sum=0000000b Cout=0 of=0",
                     bus.sum, bus.Cout, bus.of);
        end
    endtask

    task automatic test_random;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] ref_sum;
        logic        ref_of;
        int          bad;
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            ref_of  = (ra[31] == rb[31]) && (ref_sum[31] != ra[31]);
            drive(ra, rb, rc);
            @(posedge clk); #1;
            checks++;
            if (bus.sum !== ref_sum[31:0] || bus.Cout !== ref_sum[32] || bus.of !== ref_of) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_%0d: a=%h b=%h cin=%b got sum=%h Cout=%b of=%b want sum=%h Cout=%b of=%b",
                             i, ra, rb, rc, bus.sum, bus.Cout, bus.of,
                             ref_sum[31:0], ref_sum[32], ref_of);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        bus.a   = '0;
        bus.b   = '0;
        bus.Cin = 1'b0;
        test_reset();
        test_directed();
        test_boundary();
        test_latency();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
